// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: IF->ID->EX->[MEM]->WB core sequencer with handshakes and trap.
// Optional EX watchdog enabled by defining MC_EX_TIMEOUT_EN.
module multicycle_ctrl #(
  parameter int pcmux_N = 4,
  parameter int wbmux_N = 4,
  parameter int TO_W    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [6:0]                 opcode,
  input  logic                       imem_valid,
  input  logic                       exdone,
  input  logic                       br_taken,
  input  logic                       dmem_ready,
  output logic                       instrre,
  output logic                       regre,
  output logic                       exstart,
  output logic                       memre,
  output logic                       memwe,
  output logic                       regwe,
  output logic                       pcnextctl,
  output logic [$clog2(pcmux_N)-1:0] pcmuxctl,
  output logic [$clog2(wbmux_N)-1:0] wbsel,
  output logic                       trap,
  output logic [2:0]                 state_o
);

  localparam int PW = $clog2(pcmux_N);
  localparam int WW = $clog2(wbmux_N);

  localparam logic [6:0] OP_LOAD  = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BR    = 7'h63;
  localparam logic [6:0] OP_JAL   = 7'h6F;
  localparam logic [6:0] OP_JALR  = 7'h67;
  localparam logic [6:0] OP_OP    = 7'h33;
  localparam logic [6:0] OP_OPIMM = 7'h13;
  localparam logic [6:0] OP_LUI   = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  if (pcmux_N < 4 || wbmux_N < 4 || TO_W < 1) begin : g_param_chk
    $error("multicycle_ctrl: pcmux_N/wbmux_N must be >= 4, TO_W >= 1");
  end

  state_t          st_q;
  state_t          st_d;
  logic [6:0]      opc_q;
  logic            brt_q;
  logic            brt_d;
  logic            legal;
  logic            mem_op;
  logic [PW-1:0]   pm_wb;
  logic [WW-1:0]   ws_wb;

`ifdef MC_EX_TIMEOUT_EN
  localparam logic [TO_W-1:0] WD_LAST = ~TO_W'(1);
  logic [TO_W-1:0] wd_q;
  logic            wd_hit;

  // EX watchdog: zero outside EX, counts EX cycles that lack exdone
  always_ff @(posedge clk) begin
    if (rst || st_q != S_EX) begin
      wd_q <= '0;
    end else if (!exdone) begin
      wd_q <= wd_q + TO_W'(1);
    end
  end

  assign wd_hit = (wd_q == WD_LAST);
`endif

  assign mem_op  = (opc_q == OP_LOAD) || (opc_q == OP_STORE);
  assign state_o = st_q;

  // opcode legality check for the ID decision
  always_comb begin
    legal = 1'b0;
    case (opc_q)
      OP_LOAD, OP_STORE, OP_BR, OP_JAL, OP_JALR,
      OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: legal = 1'b1;
      default:                           legal = 1'b0;
    endcase
  end

  // branch flag as it will be after this edge, so WB sees a same-edge exdone
  always_comb begin
    brt_d = brt_q;
    if (st_q == S_EX && exdone) brt_d = br_taken;
  end

  // next-state logic; IF only accepts a fetch it has actually requested
  always_comb begin
    st_d = S_IF;
    unique case (st_q)
      S_IF:   st_d = (imem_valid && instrre) ? S_ID : S_IF;
      S_ID:   st_d = legal ? S_EX : S_TRAP;
      S_EX: begin
        if (exdone) begin
          st_d = mem_op ? S_MEM : S_WB;
        end else begin
          st_d = S_EX;
`ifdef MC_EX_TIMEOUT_EN
          if (wd_hit) st_d = S_TRAP;
`endif
        end
      end
      S_MEM:  st_d = dmem_ready ? S_WB : S_MEM;
      S_WB:   st_d = S_IF;
      S_TRAP: st_d = S_IF;
      default: st_d = S_IF;
    endcase
  end

  // pcmux and wbmux selects used on WB entry
  always_comb begin
    pm_wb = '0;
    ws_wb = '0;
    unique case (1'b1)
      (opc_q == OP_BR):   pm_wb = brt_d ? PW'(1) : PW'(0);
      (opc_q == OP_JAL):  pm_wb = PW'(1);
      (opc_q == OP_JALR): pm_wb = PW'(2);
      default:            pm_wb = '0;
    endcase
    unique case (1'b1)
      (opc_q == OP_LOAD):                        ws_wb = WW'(1);
      (opc_q == OP_JAL) || (opc_q == OP_JALR):   ws_wb = WW'(2);
      (opc_q == OP_LUI):                         ws_wb = WW'(3);
      default:                                   ws_wb = '0;
    endcase
  end

  // state, latched operands and outputs registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IF;
      opc_q     <= '0;
      brt_q     <= 1'b0;
      instrre   <= 1'b0;
      regre     <= 1'b0;
      exstart   <= 1'b0;
      memre     <= 1'b0;
      memwe     <= 1'b0;
      regwe     <= 1'b0;
      pcnextctl <= 1'b0;
      trap      <= 1'b0;
      pcmuxctl  <= '0;
      wbsel     <= '0;
    end else begin
      st_q  <= st_d;
      brt_q <= brt_d;
      if (st_q == S_IF && st_d == S_ID) opc_q <= opcode;
      instrre   <= (st_d == S_IF);
      regre     <= (st_d == S_ID);
      exstart   <= (st_d == S_EX) && (st_q != S_EX);
      memre     <= (st_d == S_MEM) && (opc_q == OP_LOAD);
      memwe     <= (st_d == S_MEM) && (opc_q == OP_STORE);
      regwe     <= (st_d == S_WB) && (opc_q != OP_STORE)
                   && (opc_q != OP_BR);
      pcnextctl <= (st_d == S_WB) || (st_d == S_TRAP);
      trap      <= (st_d == S_TRAP);
      if (st_d == S_WB) begin
        pcmuxctl <= pm_wb;
        wbsel    <= ws_wb;
      end else if (st_d == S_TRAP) begin
        pcmuxctl <= PW'(3);
      end
    end
  end

endmodule
